// File: rtl/isa_pkg.sv
// isa_pkg: MIPS opcode/funct constants, instruction field positions and fetch FSM states
package isa_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;
   localparam int FN_MSB  = 5;
   localparam int FN_LSB  = 0;
   localparam int TGT_MSB = 25;
   localparam int TGT_LSB = 0;
   typedef enum logic [1:0] {RESET_WAIT, REQ, HOLD, HALT} fetch_state_t;
   // Word offset of a BEQ immediate, as a byte displacement
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: sequential, branch-taken and jump target selection (jump wins)
module next_pc_calc
   import isa_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm,
   input  logic [25:0] target26,
   input  logic        branch_taken,
   input  logic        jump,
   output logic [31:0] next_pc
);
   logic [31:0] pc4;
   assign pc4 = pc + 32'd4;
   assign next_pc = jump ? {pc4[31:28], target26, 2'b00} : branch_taken ? pc4 + branch_offset(imm) : pc4;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, imem req/ack fetch and field decode; FETCH_TIMEOUT_EN adds a sticky fetch timeout
module instr_fetch_unit
   import isa_pkg::*;
#(
   parameter logic [31:0] PC_RESET       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic        instr_valid,
   output logic [5:0]  op_out,
   output logic [5:0]  func_out,
   output logic [4:0]  rs_out,
   output logic [4:0]  rt_out,
   output logic [4:0]  rd_out,
   output logic [15:0] imm_out,
   output logic [31:0] pc_out,
   output logic        fetch_err
);
   fetch_state_t state, state_nx;
   logic [31:0] pc, ir, npc;
   logic        timeout;
`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;
   logic          err;
   assign timeout   = (state == REQ) && !imem_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign fetch_err = err;
   // Count unanswered request cycles; the error flag stays set until reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         wait_cnt <= (state == REQ && !imem_ack) ? wait_cnt + 1'b1 : '0;
         if (timeout) err <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout        = 1'b0;
   assign fetch_err      = 1'b0;
`endif
   next_pc_calc u_next_pc (
      .pc           (pc),
      .imm          (ir[IMM_MSB:IMM_LSB]),
      .target26     (ir[TGT_MSB:TGT_LSB]),
      .branch_taken (branch & zero),
      .jump         (jump),
      .next_pc      (npc)
   );
   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= RESET_WAIT;
      else        state <= state_nx;
   end
   // Next state: wait for ack in REQ, hold while stalled, HALT only via timeout
   always_comb begin
      state_nx = state == RESET_WAIT ? REQ :
                 state == REQ        ? (timeout ? HALT : imem_ack ? HOLD : REQ) :
                 state == HOLD       ? (stall ? HOLD : REQ) : HALT;
   end
   // Capture the instruction on ack and advance the PC when HOLD releases
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= {PC_RESET[31:2], 2'b00};
         ir <= '0;
      end else begin
         if (state == REQ && imem_ack) ir <= imem_rdata;
         if (state == HOLD && !stall)  pc <= npc;
      end
   end
   // Moore outputs: request only in REQ, fields valid only in HOLD
   always_comb begin
      imem_req    = state == REQ;
      instr_valid = state == HOLD;
   end
   assign imem_addr = pc;
   assign pc_out    = pc;
   assign op_out    = ir[OP_MSB:OP_LSB];
   assign func_out  = ir[FN_MSB:FN_LSB];
   assign rs_out    = ir[RS_MSB:RS_LSB];
   assign rt_out    = ir[RT_MSB:RT_LSB];
   assign rd_out    = ir[RD_MSB:RD_LSB];
   assign imm_out   = ir[IMM_MSB:IMM_LSB];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench for instr_fetch_unit (optionally with FETCH_TIMEOUT_EN)
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n, imem_ack, stall, branch, zero, jump;
   logic [31:0] imem_rdata;
   logic        imem_req, instr_valid, fetch_err;
   logic [31:0] imem_addr, pc_out;
   logic [5:0]  op_out, func_out;
   logic [4:0]  rs_out, rt_out, rd_out;
   logic [15:0] imm_out;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_pc;

   instr_fetch_unit #(.PC_RESET(32'h0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .branch(branch),
      .zero(zero), .jump(jump), .instr_valid(instr_valid), .op_out(op_out),
      .func_out(func_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
      .imm_out(imm_out), .pc_out(pc_out), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Architectural next PC from the ISA rules, plain 32-bit arithmetic
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                              input bit br, input bit z, input bit j);
      logic [31:0] seq;
      int          off;
      seq = pc + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
      off = int'($signed(instr[15:0]));
      if (br && z) return seq + 32'(off * 4);
      return seq;
   endfunction

   // One full fetch: wait for request, ack after lat cycles, stall, then release with decisions
   task automatic do_fetch(input logic [31:0] instr, input int lat, input bit br, input bit z,
                           input bit j, input int stall_cyc);
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL req_wait: imem_req=%b after %0d cycles, want 1", imem_req, n);
         return;
      end
      checks++;
      if (imem_addr !== m_pc) begin
         errors++;
         $display("FAIL fetch_addr: imem_addr=%h want %h", imem_addr, m_pc);
      end
      repeat (lat) @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = instr;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc_out !== m_pc) begin
         errors++;
         $display("FAIL hold_state: valid=%b req=%b pc_out=%h want 1 0 %h", instr_valid, imem_req, pc_out, m_pc);
      end
      checks++;
      if (op_out !== 6'(instr >> 26) || rs_out !== 5'(instr >> 21) || rt_out !== 5'(instr >> 16) ||
          rd_out !== 5'(instr >> 11) || imm_out !== 16'(instr) || func_out !== 6'(instr & 32'h3F)) begin
         errors++;
         $display("FAIL fields: op=%h rs=%h rt=%h rd=%h imm=%h fn=%h for instr %h",
                  op_out, rs_out, rt_out, rd_out, imm_out, func_out, instr);
      end
      stall = 1'b1;
      for (int s = 0; s < stall_cyc; s++) begin
         branch = 1'b1;
         zero   = 1'b1;
         jump   = 1'($urandom);
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || imem_req !== 1'b0 || imm_out !== 16'(instr) || op_out !== 6'(instr >> 26) ||
             pc_out !== m_pc) begin
            errors++;
            $display("FAIL stall_hold: valid=%b req=%b imm=%h op=%h pc=%h at stall cycle %0d",
                     instr_valid, imem_req, imm_out, op_out, pc_out, s);
         end
      end
      stall  = 1'b0;
      branch = br;
      zero   = z;
      jump   = j;
      @(negedge clk);
      branch = 1'b0;
      zero   = 1'b0;
      jump   = 1'b0;
      m_pc   = model_next(m_pc, instr, br, z, j);
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== m_pc) begin
         errors++;
         $display("FAIL next_req: valid=%b req=%b addr=%h want 0 1 %h", instr_valid, imem_req, imem_addr, m_pc);
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      stall      = 1'b0;
      branch     = 1'b0;
      zero       = 1'b0;
      jump       = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: req=%b valid=%b err=%b want 0 0 0", imem_req, instr_valid, fetch_err);
      end
      checks++;
      if (pc_out !== 32'h0 || op_out !== 6'h0 || func_out !== 6'h0 || rs_out !== 5'h0 ||
          rt_out !== 5'h0 || rd_out !== 5'h0 || imm_out !== 16'h0) begin
         errors++;
         $display("FAIL reset_fields: pc=%h op=%h fn=%h imm=%h want all 0", pc_out, op_out, func_out, imm_out);
      end
      imem_ack = 1'b0;
      rst_n    = 1'b1;
      m_pc     = 32'h0;
   endtask

   task automatic test_sequential();
      logic [31:0] addrs [3];
      addrs = '{32'h0, 32'h4, 32'h8};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (imem_addr !== addrs[i] || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL seq_addr: addr=%h req=%b want %h 1", imem_addr, imem_req, addrs[i]);
         end
         do_fetch(i == 0 ? 32'h012A_4020 : (i == 1 ? 32'h0 : $urandom & 32'h03FF_FFFF), 1, 0, 0, 0, 0);
      end
      checks++;
      if (op_out !== 6'h0) begin
         errors++;
         $display("FAIL seq_op: op=%h want 0", op_out);
      end
   endtask

   task automatic test_branch();
      do_fetch(32'h0800_0010, 1, 0, 0, 1, 0);
      checks++;
      if (imem_addr !== 32'h40) begin
         errors++;
         $display("FAIL jump_to_40: addr=%h want 00000040", imem_addr);
      end
      do_fetch(32'h1000_FFFF, 2, 1, 1, 0, 0);
      checks++;
      if (imem_addr !== 32'h40) begin
         errors++;
         $display("FAIL beq_taken: addr=%h want 00000040", imem_addr);
      end
      do_fetch(32'h1000_FFFF, 1, 1, 0, 0, 0);
      checks++;
      if (imem_addr !== 32'h44) begin
         errors++;
         $display("FAIL beq_not_taken: addr=%h want 00000044", imem_addr);
      end
   endtask

   task automatic test_jump();
      do_fetch(32'h0800_0040, 1, 0, 0, 1, 0);
      checks++;
      if (imem_addr !== 32'h100) begin
         errors++;
         $display("FAIL jump_to_100: addr=%h want 00000100", imem_addr);
      end
      do_fetch(32'h0800_0010, 1, 1, 1, 1, 0);
      checks++;
      if (imem_addr !== 32'h40) begin
         errors++;
         $display("FAIL jump_priority: addr=%h want 00000040", imem_addr);
      end
   endtask

   task automatic test_stall();
      do_fetch(32'h012A_4022, 2, 0, 0, 0, 5);
      checks++;
      if (imem_addr !== 32'h44) begin
         errors++;
         $display("FAIL stall_release: addr=%h want 00000044", imem_addr);
      end
   endtask

   task automatic test_wrap();
      int          off;
      logic [31:0] beq;
      off = int'(32'hFFFF_FFFC - (m_pc + 32'd4)) >>> 2;
      beq = 32'h1000_0000 | (32'(off) & 32'h0000_FFFF);
      do_fetch(beq, 1, 1, 1, 0, 0);
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_setup: addr=%h want fffffffc", imem_addr);
      end
      do_fetch(32'h2128_0005, 1, 0, 1, 0, 0);
      checks++;
      if (imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap: addr=%h want 00000000", imem_addr);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         do_fetch($urandom, $urandom_range(1, 3), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2));
      end
   endtask

   task automatic test_reset_mid_req();
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 32'h8C00_0000;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_out !== 32'h0) begin
         errors++;
         $display("FAIL mid_req_reset: valid=%b req=%b pc=%h want 0 0 0", instr_valid, imem_req, pc_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL post_reset_req: valid=%b req=%b addr=%h want 0 1 0", instr_valid, imem_req, imem_addr);
      end
      m_pc = 32'h0;
      do_fetch(32'hAC01_0004, 1, 0, 0, 0, 0);
   endtask

   task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
      repeat (15) @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL pre_timeout: req=%b err=%b want 1 0", imem_req, fetch_err);
      end
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout: req=%b err=%b valid=%b want 0 1 0", imem_req, fetch_err, instr_valid);
      end
      for (int i = 0; i < 4; i++) begin
         imem_ack = 1'($urandom);
         @(negedge clk);
      end
      imem_ack = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_sticky: req=%b err=%b valid=%b want 0 1 0", imem_req, fetch_err, instr_valid);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err=%b want 0", fetch_err);
      end
      rst_n = 1'b1;
      m_pc  = 32'h0;
      do_fetch(32'h1234_5678, 1, 0, 0, 0, 0);
`else
      repeat (20) @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout: req=%b err=%b want 1 0", imem_req, fetch_err);
      end
      do_fetch(32'h1234_5678, 1, 0, 0, 0, 0);
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_stall();
      test_wrap();
      test_random();
      test_reset_mid_req();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
